out_channel_checker: RTL and testbench



---
 rtl/out_channel_checker.sv | 111 +++++++++++
 tb/tb_out_channel_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_channel_checker.sv
// Out-channel checker: compares core output words in order against a preloaded
// expected table and reports mismatches, overflow, underflow and stall timeout.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NExpected          = 16,
  parameter int TimeoutCycles      = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             expWrite,
  input  logic [$clog2(NExpected)-1:0]     expAddr,
  input  logic [MemoryElementWidth-1:0]    expData,
  input  logic [$clog2(NExpected):0]       expCount,
  input  logic                             start,
  input  logic                             outValid,
  input  logic [MemoryElementWidth-1:0]    outData,
  output logic                             outReady,
  input  logic                             programDone,
  output logic                             finished,
  output logic                             success,
  output logic [$clog2(NExpected):0]       mismatches,
  output logic [$clog2(NExpected):0]       firstBad,
  output logic                             timedOut
);

  localparam int AW    = $clog2(NExpected);
  localparam int CW    = AW + 1;
  localparam int IdleW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                    state;
  logic [CW-1:0]                 limit;
  logic [CW-1:0]                 index;
  logic [IdleW-1:0]              idleCnt;
  logic                          overflow;
  logic [MemoryElementWidth-1:0] expTable [NExpected];

  logic transfer;
  logic tooFew;
  logic noBadYet;

  assign outReady = (state == CHECK);
  assign transfer = outValid && outReady;
  assign tooFew   = (index < limit);
  assign noBadYet = (firstBad == '1);

  // Table has no reset so it survives a mid-run abort and can be rerun.
  always_ff @(posedge clock) begin
    if (state == IDLE && expWrite) begin
      expTable[expAddr] <= expData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      limit      <= '0;
      index      <= '0;
      idleCnt    <= '0;
      overflow   <= 1'b0;
      finished   <= 1'b0;
      success    <= 1'b0;
      timedOut   <= 1'b0;
      mismatches <= '0;
      firstBad   <= '1;
    end else if (state != CHECK && start) begin
      // Limit is clamped to the table depth so the table index never runs past it.
      limit      <= (expCount > CW'(NExpected)) ? CW'(NExpected) : expCount;
      index      <= '0;
      idleCnt    <= '0;
      overflow   <= 1'b0;
      finished   <= 1'b0;
      success    <= 1'b0;
      timedOut   <= 1'b0;
      mismatches <= '0;
      firstBad   <= '1;
      state      <= CHECK;
    end else if (state == CHECK) begin
      if (transfer) begin
        idleCnt <= '0;
        if (tooFew) begin
          if (outData != expTable[index[AW-1:0]]) begin
            if (mismatches != '1) mismatches <= mismatches + CW'(1);
            if (noBadYet) firstBad <= index;
          end
        end else begin
          overflow <= 1'b1;
          if (noBadYet) firstBad <= index;
        end
        if (index != '1) index <= index + CW'(1);
      end else if (programDone) begin
        state    <= DONE;
        finished <= 1'b1;
        success  <= (mismatches == '0) && !overflow && (index == limit);
        if (tooFew && noBadYet) firstBad <= index;
      end else if (idleCnt == IdleW'(TimeoutCycles - 1)) begin
        state    <= DONE;
        finished <= 1'b1;
        timedOut <= 1'b1;
        success  <= 1'b0;
        if (tooFew && noBadYet) firstBad <= index;
      end else begin
        idleCnt <= idleCnt + IdleW'(1);
      end
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed self-checking bench for out_channel_checker (TimeoutCycles = 8).
module tb_out_channel_checker;

  localparam int W  = 12;
  localparam int NE = 16;
  localparam int AW = 4;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          expWrite = 1'b0;
  logic [AW-1:0] expAddr = '0;
  logic [W-1:0]  expData = '0;
  logic [CW-1:0] expCount = '0;
  logic          start = 1'b0;
  logic          outValid = 1'b0;
  logic [W-1:0]  outData = '0;
  logic          outReady;
  logic          programDone = 1'b0;
  logic          finished;
  logic          success;
  logic [CW-1:0] mismatches;
  logic [CW-1:0] firstBad;
  logic          timedOut;

  int tests  = 0;
  int failed = 0;

  out_channel_checker #(
    .MemoryElementWidth(W),
    .NExpected(NE),
    .TimeoutCycles(8)
  ) dut (
    .clock(clock), .reset(reset), .expWrite(expWrite), .expAddr(expAddr),
    .expData(expData), .expCount(expCount), .start(start), .outValid(outValid),
    .outData(outData), .outReady(outReady), .programDone(programDone),
    .finished(finished), .success(success), .mismatches(mismatches),
    .firstBad(firstBad), .timedOut(timedOut)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0; expWrite = 1'b0; start = 1'b0; outValid = 1'b0; programDone = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic writeEntry(input logic [AW-1:0] a, input logic [W-1:0] d);
    expWrite = 1'b1; expAddr = a; expData = d;
    tick();
    expWrite = 1'b0;
  endtask

  task automatic startRun(input logic [CW-1:0] c);
    programDone = 1'b0; expCount = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendWord(input logic [W-1:0] d);
    outValid = 1'b1; outData = d;
    tick();
    outValid = 1'b0;
  endtask

  task automatic finishRun();
    programDone = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tests++; if (outReady !== 1'b0) begin $display("FAIL rst_outReady got %0h expected 0", outReady); failed++; end
    tests++; if (finished !== 1'b0) begin $display("FAIL rst_finished got %0h expected 0", finished); failed++; end
    tests++; if (success !== 1'b0) begin $display("FAIL rst_success got %0h expected 0", success); failed++; end
    tests++; if (timedOut !== 1'b0) begin $display("FAIL rst_timedOut got %0h expected 0", timedOut); failed++; end
    tests++; if (mismatches !== 5'd0) begin $display("FAIL rst_mismatches got %0h expected 0", mismatches); failed++; end
    tests++; if (firstBad !== 5'h1F) begin $display("FAIL rst_firstBad got %0h expected 1f", firstBad); failed++; end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_pass();
    doReset();
    writeEntry(4'd0, 12'd2);
    startRun(5'd1);
    tests++; if (outReady !== 1'b1) begin $display("FAIL pass_outReady got %0h expected 1", outReady); failed++; end
    sendWord(12'd2);
    tests++; if (finished !== 1'b0) begin $display("FAIL pass_early_finished got %0h expected 0", finished); failed++; end
    finishRun();
    tests++; if (finished !== 1'b1) begin $display("FAIL pass_finished got %0h expected 1", finished); failed++; end
    tests++; if (success !== 1'b1) begin $display("FAIL pass_success got %0h expected 1", success); failed++; end
    tests++; if (mismatches !== 5'd0) begin $display("FAIL pass_mismatches got %0h expected 0", mismatches); failed++; end
    tests++; if (firstBad !== 5'h1F) begin $display("FAIL pass_firstBad got %0h expected 1f", firstBad); failed++; end
    tests++; if (outReady !== 1'b0) begin $display("FAIL pass_done_outReady got %0h expected 0", outReady); failed++; end
  endtask

  task automatic test_restart();
    // Still in DONE from the previous run: table write must be ignored.
    writeEntry(4'd0, 12'd3);
    startRun(5'd1);
    tests++; if (finished !== 1'b0) begin $display("FAIL rs_cleared got %0h expected 0", finished); failed++; end
    sendWord(12'd2);
    expCount = 5'd5; start = 1'b1;
    tick();
    start = 1'b0;
    finishRun();
    tests++; if (success !== 1'b1) begin $display("FAIL rs_success got %0h expected 1", success); failed++; end
    tests++; if (mismatches !== 5'd0) begin $display("FAIL rs_mismatches got %0h expected 0", mismatches); failed++; end
    startRun(5'd0);
    finishRun();
    tests++; if (success !== 1'b1) begin $display("FAIL lim0_success got %0h expected 1", success); failed++; end
    startRun(5'd0);
    sendWord(12'd5);
    finishRun();
    tests++; if (success !== 1'b0) begin $display("FAIL lim0ovf_success got %0h expected 0", success); failed++; end
    tests++; if (firstBad !== 5'd0) begin $display("FAIL lim0ovf_firstBad got %0h expected 0", firstBad); failed++; end
  endtask

  task automatic test_mismatch();
    doReset();
    writeEntry(4'd0, 12'd5);
    writeEntry(4'd1, 12'd7);
    writeEntry(4'd2, 12'd9);
    startRun(5'd3);
    sendWord(12'd5);
    sendWord(12'd8);
    tests++; if (mismatches !== 5'd1) begin $display("FAIL mm_live_count got %0h expected 1", mismatches); failed++; end
    tests++; if (firstBad !== 5'd1) begin $display("FAIL mm_live_firstBad got %0h expected 1", firstBad); failed++; end
    sendWord(12'd9);
    finishRun();
    tests++; if (finished !== 1'b1) begin $display("FAIL mm_finished got %0h expected 1", finished); failed++; end
    tests++; if (success !== 1'b0) begin $display("FAIL mm_success got %0h expected 0", success); failed++; end
    tests++; if (mismatches !== 5'd1) begin $display("FAIL mm_count got %0h expected 1", mismatches); failed++; end
    tests++; if (firstBad !== 5'd1) begin $display("FAIL mm_firstBad got %0h expected 1", firstBad); failed++; end
  endtask

  task automatic test_overflow();
    doReset();
    writeEntry(4'd0, 12'd1);
    writeEntry(4'd1, 12'd1);
    startRun(5'd2);
    sendWord(12'd1);
    sendWord(12'd1);
    sendWord(12'd1);
    finishRun();
    tests++; if (success !== 1'b0) begin $display("FAIL ovf_success got %0h expected 0", success); failed++; end
    tests++; if (firstBad !== 5'd2) begin $display("FAIL ovf_firstBad got %0h expected 2", firstBad); failed++; end
    tests++; if (mismatches !== 5'd0) begin $display("FAIL ovf_mismatches got %0h expected 0", mismatches); failed++; end
  endtask

  task automatic test_too_few();
    doReset();
    writeEntry(4'd0, 12'd1);
    writeEntry(4'd1, 12'd1);
    startRun(5'd2);
    sendWord(12'd1);
    finishRun();
    tests++; if (finished !== 1'b1) begin $display("FAIL few_finished got %0h expected 1", finished); failed++; end
    tests++; if (success !== 1'b0) begin $display("FAIL few_success got %0h expected 0", success); failed++; end
    tests++; if (firstBad !== 5'd1) begin $display("FAIL few_firstBad got %0h expected 1", firstBad); failed++; end
  endtask

  task automatic test_timeout();
    doReset();
    startRun(5'd1);
    repeat (7) tick();
    tests++; if (finished !== 1'b0) begin $display("FAIL to_early_finished got %0h expected 0", finished); failed++; end
    tests++; if (timedOut !== 1'b0) begin $display("FAIL to_early_timedOut got %0h expected 0", timedOut); failed++; end
    tick();
    tests++; if (timedOut !== 1'b1) begin $display("FAIL to_timedOut got %0h expected 1", timedOut); failed++; end
    tests++; if (finished !== 1'b1) begin $display("FAIL to_finished got %0h expected 1", finished); failed++; end
    tests++; if (success !== 1'b0) begin $display("FAIL to_success got %0h expected 0", success); failed++; end
  endtask

  task automatic test_back_to_back();
    doReset();
    writeEntry(4'd0, 12'd4);
    writeEntry(4'd1, 12'd6);
    writeEntry(4'd2, 12'h8FF);
    startRun(5'd3);
    sendWord(12'd4);
    sendWord(12'd0);
    #2 reset = 1'b0;
    #1;
    tests++; if (outReady !== 1'b0) begin $display("FAIL ar_outReady got %0h expected 0", outReady); failed++; end
    tests++; if (mismatches !== 5'd0) begin $display("FAIL ar_mismatches got %0h expected 0", mismatches); failed++; end
    tests++; if (firstBad !== 5'h1F) begin $display("FAIL ar_firstBad got %0h expected 1f", firstBad); failed++; end
    tick();
    reset = 1'b1;
    tick();
    startRun(5'd3);
    sendWord(12'd4);
    sendWord(12'd6);
    outValid = 1'b1; outData = 12'h8FF; programDone = 1'b1;
    tick();
    outValid = 1'b0;
    tests++; if (finished !== 1'b0) begin $display("FAIL b2b_same_cycle_finished got %0h expected 0", finished); failed++; end
    tick();
    tests++; if (finished !== 1'b1) begin $display("FAIL b2b_finished got %0h expected 1", finished); failed++; end
    tests++; if (success !== 1'b1) begin $display("FAIL b2b_success got %0h expected 1", success); failed++; end
    tests++; if (firstBad !== 5'h1F) begin $display("FAIL b2b_firstBad got %0h expected 1f", firstBad); failed++; end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_restart();
    test_mismatch();
    test_overflow();
    test_too_few();
    test_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
